fft_input_framer: RTL and testbench

- Upstream feeder of the N-point FFT core.
- Accepts one complex-packed sample per cycle over a valid/ready stream and writes sample i of each frame into bit-reversed position bitrev(i).
- Presents complete frames as one wide parallel word with a valid/ready handshake.
- Ping-pong buffered (two frame banks), so bank B can fill while bank A waits for the core.

---
 rtl/fft_input_framer.sv | 122 ++++++++++++
 tb/tb_fft_input_framer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_framer.sv
// Ping-pong sample framer for the FFT core: samples land in bit-reversed slots
// of the write bank; completed banks are offered as one wide word in arrival order.
module fft_input_framer #(
  parameter int NO_STAGES    = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      flush,
  input  logic                                      s_valid,
  output logic                                      s_ready,
  input  logic [SAMPLE_WIDTH-1:0]                   s_data,
  input  logic                                      s_last,
  output logic                                      frame_valid,
  input  logic                                      frame_ready,
  output logic [(1<<NO_STAGES)*SAMPLE_WIDTH-1:0]    frame_data,
  output logic [CNT_WIDTH-1:0]                      frame_count,
  output logic                                      error
);

  localparam int N_POINT_FFT = 1 << NO_STAGES;
  localparam logic [NO_STAGES-1:0] LAST_IDX = NO_STAGES'(N_POINT_FFT - 1);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // ready never depends on valid, and valid/data hold until the transfer.
  logic [SAMPLE_WIDTH-1:0] bank_q [2][N_POINT_FFT];
  logic [1:0]              full_q, full_d;
  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [NO_STAGES-1:0]    wr_idx_q, wr_idx_d;
  logic [CNT_WIDTH-1:0]    frame_count_q, frame_count_d;
  logic                    error_q, error_d;
  logic                    accept;
  logic                    handshake;

  function automatic logic [NO_STAGES-1:0] bitrev(input logic [NO_STAGES-1:0] v);
    logic [NO_STAGES-1:0] r;
    r = '0;
    for (int b = 0; b < NO_STAGES; b++) r[b] = v[NO_STAGES-1-b];
    return r;
  endfunction

  assign s_ready     = !full_q[wr_bank_q];
  assign frame_valid = full_q[rd_bank_q];
  assign frame_count = frame_count_q;
  assign error       = error_q;
  assign accept      = s_valid && s_ready;
  assign handshake   = frame_valid && frame_ready;

  always_comb begin
    full_d        = full_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    wr_idx_d      = wr_idx_q;
    frame_count_d = frame_count_q;
    error_d       = error_q;
    if (flush) begin
      full_d    = 2'b00;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      wr_idx_d  = '0;
      error_d   = 1'b0;
    end else begin
      // Read and write banks differ whenever both events fire, so both updates apply.
      if (handshake) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        frame_count_d     = frame_count_q + CNT_WIDTH'(1);
      end
      if (accept) begin
        if (wr_idx_q == LAST_IDX) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = !wr_bank_q;
          wr_idx_d          = '0;
          if (!s_last) error_d = 1'b1;
        end else if (s_last) begin
          wr_idx_d = '0;
          error_d  = 1'b1;
        end else begin
          wr_idx_d = wr_idx_q + NO_STAGES'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q        <= 2'b00;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      frame_count_q <= '0;
      error_q       <= 1'b0;
    end else begin
      full_q        <= full_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_idx_q      <= wr_idx_d;
      frame_count_q <= frame_count_d;
      error_q       <= error_d;
    end
  end

  // Bank contents survive flush; stale slots are simply overwritten by later frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < N_POINT_FFT; k++)
          bank_q[b][k] <= '0;
    end else if (!flush && accept) begin
      bank_q[wr_bank_q][bitrev(wr_idx_q)] <= s_data;
    end
  end

  always_comb begin
    frame_data = '0;
    for (int k = 0; k < N_POINT_FFT; k++)
      frame_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = bank_q[rd_bank_q][k];
  end

endmodule

// File: tb/tb_fft_input_framer.sv
// Directed bench for fft_input_framer: stimulus pushes expected frames into a queue,
// a negedge monitor pops and compares on every frame handshake.
module tb_fft_input_framer;

  localparam int FW = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main DUT (16-point, 16-bit samples, 16-bit counter)
  logic          flush = 1'b0, s_valid = 1'b0, s_last = 1'b0, frame_ready = 1'b0;
  logic [15:0]   s_data = '0;
  logic          s_ready, frame_valid, error;
  logic [FW-1:0] frame_data;
  logic [15:0]   frame_count;

  fft_input_framer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_data(frame_data), .frame_count(frame_count), .error(error)
  );

  // small DUT for counter wrap (4-point, 8-bit samples, 4-bit counter)
  logic        w_s_valid = 1'b0, w_s_last = 1'b0, w_frame_ready = 1'b0;
  logic [7:0]  w_s_data = '0;
  logic        w_s_ready, w_frame_valid, w_error;
  logic [31:0] w_frame_data;
  logic [3:0]  w_frame_count;

  fft_input_framer #(.NO_STAGES(2), .SAMPLE_WIDTH(8), .CNT_WIDTH(4)) dut_w (
    .clk(clk), .reset(reset), .flush(1'b0),
    .s_valid(w_s_valid), .s_ready(w_s_ready), .s_data(w_s_data), .s_last(w_s_last),
    .frame_valid(w_frame_valid), .frame_ready(w_frame_ready),
    .frame_data(w_frame_data), .frame_count(w_frame_count), .error(w_error)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [FW-1:0] exp_q[$];
  logic [15:0]   exp_cnt = '0;
  int br_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] build_frame(input logic [15:0] base);
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < 16; i++) f[br_tab[i]*16 +: 16] = base + 16'(i);
    return f;
  endfunction

  always @(negedge clk) begin
    if (!reset && frame_valid && frame_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got %0h expected none", frame_data);
      end else begin
        check("frame_data", frame_data, exp_q.pop_front());
        check("frame_count_at_hs", FW'(frame_count), FW'(exp_cnt));
      end
      exp_cnt = exp_cnt + 16'd1;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_sample(input logic [15:0] d, input logic l);
    int budget;
    budget = 200;
    s_valid = 1'b1; s_data = d; s_last = l;
    @(negedge clk);
    while (!s_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("s_ready_timeout", FW'(s_ready), FW'(1));
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // last_at < 0 means no s_last in the burst
  task automatic send_burst(input logic [15:0] base, input int n, input int last_at);
    for (int i = 0; i < n; i++) send_sample(base + 16'(i), i == last_at);
  endtask

  task automatic send_w_sample(input logic [7:0] d, input logic l);
    int budget;
    budget = 200;
    w_s_valid = 1'b1; w_s_data = d; w_s_last = l;
    @(negedge clk);
    while (!w_s_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("w_s_ready_timeout", FW'(w_s_ready), FW'(1));
    @(posedge clk); #1;
    w_s_valid = 1'b0; w_s_last = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed test sequence ----------------
  initial begin
    logic [15:0] cnt_before;
    cycles(2);
    check("rst_s_ready", FW'(s_ready), FW'(1));
    check("rst_frame_valid", FW'(frame_valid), FW'(0));
    check("rst_frame_data", frame_data, '0);
    check("rst_frame_count", FW'(frame_count), FW'(0));
    check("rst_error", FW'(error), FW'(0));
    reset = 1'b0;
    cycles(1);

    // 1) single frame 0..15, consumer ready
    frame_ready = 1'b1;
    exp_q.push_back(build_frame(16'h0000));
    send_burst(16'h0000, 16, 15);
    check("t1_latency_valid", FW'(frame_valid), FW'(1));
    check("t1_slot1", FW'(frame_data[1*16 +: 16]), FW'(8));
    check("t1_slot8", FW'(frame_data[8*16 +: 16]), FW'(1));
    check("t1_slot15", FW'(frame_data[15*16 +: 16]), FW'(15));
    cycles(1);
    check("t1_count", FW'(frame_count), FW'(1));
    check("t1_error", FW'(error), FW'(0));
    check("t1_valid_drop", FW'(frame_valid), FW'(0));

    // 2) backpressure: two frames buffered, third waits for space
    frame_ready = 1'b0;
    exp_q.push_back(build_frame(16'h0100));
    send_burst(16'h0100, 16, 15);
    exp_q.push_back(build_frame(16'h0200));
    send_burst(16'h0200, 16, 15);
    check("t2_s_ready_full", FW'(s_ready), FW'(0));
    cycles(3);
    check("t2_held_valid", FW'(frame_valid), FW'(1));
    check("t2_held_data", frame_data, build_frame(16'h0100));
    frame_ready = 1'b1;
    cycles(1);
    check("t2_s_ready_back", FW'(s_ready), FW'(1));
    check("t2_count_2", FW'(frame_count), FW'(2));
    cycles(1);
    check("t2_count_3", FW'(frame_count), FW'(3));
    exp_q.push_back(build_frame(16'h0300));
    send_burst(16'h0300, 16, 15);
    cycles(2);
    check("t2_count_4", FW'(frame_count), FW'(4));

    // 3) early s_last discards partial frame
    send_burst(16'h0400, 5, 4);
    cycles(2);
    check("t3_error", FW'(error), FW'(1));
    check("t3_no_valid", FW'(frame_valid), FW'(0));
    check("t3_count", FW'(frame_count), FW'(4));
    exp_q.push_back(build_frame(16'h0500));
    send_burst(16'h0500, 16, 15);
    cycles(2);
    check("t3_count_after", FW'(frame_count), FW'(5));

    // 4) missing s_last still completes; flush clears state but not count
    do_flush();
    check("t4_flush_error", FW'(error), FW'(0));
    exp_q.push_back(build_frame(16'h0600));
    send_burst(16'h0600, 16, -1);
    cycles(2);
    check("t4_error", FW'(error), FW'(1));
    check("t4_count", FW'(frame_count), FW'(6));
    frame_ready = 1'b0;
    send_burst(16'h0700, 16, 15);
    cycles(1);
    check("t4_pending_valid", FW'(frame_valid), FW'(1));
    cnt_before = frame_count;
    do_flush();
    check("t4_flush_valid", FW'(frame_valid), FW'(0));
    check("t4_flush_error2", FW'(error), FW'(0));
    check("t4_flush_count", FW'(frame_count), FW'(6));
    check("t4_flush_count_hold", FW'(frame_count), FW'(cnt_before));
    check("t4_flush_s_ready", FW'(s_ready), FW'(1));

    // 5) asynchronous reset mid-frame
    frame_ready = 1'b1;
    send_burst(16'h0800, 7, -1);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_s_ready", FW'(s_ready), FW'(1));
    check("t5_rst_valid", FW'(frame_valid), FW'(0));
    check("t5_rst_data", frame_data, '0);
    check("t5_rst_count", FW'(frame_count), FW'(0));
    check("t5_rst_error", FW'(error), FW'(0));
    exp_q.delete();
    exp_cnt = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.push_back(build_frame(16'h0900));
    send_burst(16'h0900, 16, 15);
    cycles(2);
    check("t5_count", FW'(frame_count), FW'(1));
    check("t5_error", FW'(error), FW'(0));

    // 6) counter wrap on the 4-bit-counter instance
    w_frame_ready = 1'b1;
    for (int f = 0; f < 15; f++)
      for (int i = 0; i < 4; i++)
        send_w_sample({f[3:0], i[3:0]}, i == 3);
    cycles(2);
    check("t6_count_max", FW'(w_frame_count), FW'(4'hF));
    w_frame_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_w_sample({4'hF, i[3:0]}, i == 3);
    check("t6_valid", FW'(w_frame_valid), FW'(1));
    check("t6_bitrev4", FW'(w_frame_data), FW'(32'hF3F1F2F0));
    w_frame_ready = 1'b1;
    cycles(1);
    check("t6_count_wrap", FW'(w_frame_count), FW'(0));
    check("t6_valid_drop", FW'(w_frame_valid), FW'(0));
    check("t6_error", FW'(w_error), FW'(0));

    cycles(2);
    check("pending_frames", FW'(exp_q.size()), FW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
